// File: rtl/lab_pkg.sv
// Shared definitions for the lab board counter: FSM state encoding and default widths.
package lab_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_MANUAL = 2'd1;
    localparam logic [1:0] ST_AUTO   = 2'd2;
    localparam logic [1:0] ST_PAUSE  = 2'd3;

    localparam int CNT_W_DEFAULT = 8;

endpackage

// File: rtl/tick_gen.sv
// Prescaler for the auto-step rate: one-cycle tick every PRESCALE enabled cycles.
module tick_gen #(
    parameter int PRESCALE = 4
) (
    input  logic clk100_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic restart_i,
    output logic tick_o
);

    localparam int PW = $clog2(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_q, pre_d;
    logic          tick_q, tick_d;

    // Tick is registered off the terminal count, so it lands PRESCALE cycles after a restart.
    always_comb begin
        pre_d  = '0;
        tick_d = 1'b0;
        if (en_i && !restart_i) begin
            if (pre_q == LAST) begin
                tick_d = 1'b1;
            end else begin
                pre_d = pre_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk100_i) begin
        if (rst_i) begin
            pre_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            tick_q <= tick_d;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/count_sequencer.sv
// Mode controller and count register for the counter display: arbitrates manual
// clicks against prescaled auto ticks, with pause/resume, wrap and clear.
module count_sequencer
    import lab_pkg::*;
#(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 4,
    parameter int CNT_W   = CNT_W_DEFAULT,
    parameter int MAX_VAL = 2**CNT_W - 1
) (
    input  logic             clk100_i,
    input  logic             rst_i,
    input  logic             click_i,
    input  logic             clr_i,
    input  logic             run_i,
    input  logic             dir_i,
    input  logic [9:0]       sw_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic [9:0]       q_o,
    output logic [1:0]       state_o,
    output logic             tick_o,
    output logic             wrap_o
);

    localparam int PRESCALE = CLK_HZ / TICK_HZ;
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_VAL);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [9:0]       q_q, q_d;
    logic             wrap_q, wrap_d;
    logic             tick;
    logic             click_eff;
    logic             step_man, step_auto;

    // A clear swallows a coincident click but run-driven transitions still happen.
    assign click_eff = click_i & ~clr_i;

    always_comb begin
        state_d   = state_q;
        step_man  = 1'b0;
        step_auto = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (click_eff) begin
                    state_d  = ST_MANUAL;
                    step_man = 1'b1;
                end else if (run_i) begin
                    state_d = ST_AUTO;
                end
            end
            ST_MANUAL: begin
                if (click_eff)  step_man = 1'b1;
                else if (run_i) state_d  = ST_AUTO;
            end
            ST_AUTO: begin
                if (click_eff)   state_d   = ST_PAUSE;
                else if (!run_i) state_d   = ST_MANUAL;
                else if (tick)   step_auto = 1'b1;
            end
            default: begin
                if (!run_i)         state_d = ST_MANUAL;
                else if (click_eff) state_d = ST_AUTO;
            end
        endcase
    end

    always_comb begin
        cnt_d  = cnt_q;
        q_d    = q_q;
        wrap_d = 1'b0;
        if (clr_i) begin
            cnt_d = '0;
        end else if (step_man || step_auto) begin
            if (dir_i) begin
                if (cnt_q == '0) begin
                    cnt_d  = MAX_C;
                    wrap_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end else begin
                if (cnt_q == MAX_C) begin
                    cnt_d  = '0;
                    wrap_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
        if (step_man) q_d = sw_i;
    end

    always_ff @(posedge clk100_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            q_q     <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            wrap_q  <= wrap_d;
        end
    end

    // Prescaler runs only while staying in AUTO; any entry or clear restarts it.
    tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick_gen (
        .clk100_i  (clk100_i),
        .rst_i     (rst_i),
        .en_i      (state_d == ST_AUTO),
        .restart_i (clr_i || (state_q != ST_AUTO)),
        .tick_o    (tick)
    );

    assign cnt_o   = cnt_q;
    assign q_o     = q_q;
    assign state_o = state_q;
    assign tick_o  = tick;
    assign wrap_o  = wrap_q;

endmodule

// File: tb/tb_count_sequencer.sv
// Randomized and directed bench for count_sequencer against a cycle-level reference model.
module tb_count_sequencer;

    localparam int CLK_HZ   = 8;
    localparam int TICK_HZ  = 2;
    localparam int CNT_W    = 4;
    localparam int MAX_VAL  = 9;
    localparam int PRESCALE = CLK_HZ / TICK_HZ;

    logic             clk = 1'b0;
    logic             rst_i = 1'b1;
    logic             click_i = 1'b0;
    logic             clr_i = 1'b0;
    logic             run_i = 1'b0;
    logic             dir_i = 1'b0;
    logic [9:0]       sw_i = '0;
    logic [CNT_W-1:0] cnt_o;
    logic [9:0]       q_o;
    logic [1:0]       state_o;
    logic             tick_o;
    logic             wrap_o;

    always #5 clk = ~clk;

    count_sequencer #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ),
        .CNT_W   (CNT_W),
        .MAX_VAL (MAX_VAL)
    ) dut (
        .clk100_i (clk),
        .rst_i    (rst_i),
        .click_i  (click_i),
        .clr_i    (clr_i),
        .run_i    (run_i),
        .dir_i    (dir_i),
        .sw_i     (sw_i),
        .cnt_o    (cnt_o),
        .q_o      (q_o),
        .state_o  (state_o),
        .tick_o   (tick_o),
        .wrap_o   (wrap_o)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: mode name as an integer, count as plain modular arithmetic,
    // and the prescaler as "cycles spent continuously in AUTO since the last restart".
    int m_state = 0;
    int m_cnt   = 0;
    int m_q     = 0;
    int m_since = 0;
    bit m_tick  = 0;
    bit m_wrap  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        int ns;
        bit ck, stepm, stepa;
        if (rst_i) begin
            m_state = 0; m_cnt = 0; m_q = 0; m_since = 0; m_tick = 0; m_wrap = 0;
            return;
        end
        ns = m_state;
        ck = click_i && !clr_i;
        stepm = 0;
        stepa = 0;
        case (m_state)
            0: if (ck) begin ns = 1; stepm = 1; end else if (run_i) ns = 2;
            1: if (ck) stepm = 1; else if (run_i) ns = 2;
            2: if (ck) ns = 3; else if (!run_i) ns = 1; else if (m_tick) stepa = 1;
            default: if (!run_i) ns = 1; else if (ck) ns = 2;
        endcase
        m_wrap = 0;
        if (clr_i) begin
            m_cnt = 0;
        end else if (stepm || stepa) begin
            m_wrap = dir_i ? (m_cnt == 0) : (m_cnt == MAX_VAL);
            m_cnt  = dir_i ? (m_cnt + MAX_VAL) % (MAX_VAL + 1) : (m_cnt + 1) % (MAX_VAL + 1);
            if (stepm) m_q = int'(sw_i);
        end
        if (ns == 2 && m_state == 2 && !clr_i) m_since++;
        else m_since = 0;
        m_tick  = (m_since > 0) && (m_since % PRESCALE == 0);
        m_state = ns;
    endtask

    // One clock: drive inputs, advance the model at the edge, compare all outputs 1ns later.
    task automatic cyc(input logic r, input logic c, input logic cl, input logic rn);
        rst_i   = r;
        click_i = c;
        clr_i   = cl;
        run_i   = rn;
        @(posedge clk);
        model_edge();
        #1;
        check("cnt",   32'(cnt_o),   32'(m_cnt));
        check("q",     32'(q_o),     32'(m_q));
        check("state", 32'(state_o), 32'(m_state));
        check("tick",  32'(tick_o),  32'(m_tick));
        check("wrap",  32'(wrap_o),  32'(m_wrap));
        @(negedge clk);
    endtask

    initial begin
        int n_ticks;
        int first;
        logic [CNT_W-1:0] held;

        @(negedge clk);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        check("reset_cnt", 32'(cnt_o), 0);
        check("reset_state", 32'(state_o), 0);
        check("reset_q", 32'(q_o), 0);

        // Three manual steps capture sw_i.
        dir_i = 0;
        sw_i  = 10'h2A5;
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 0, 0);
            cyc(0, 0, 0, 0);
        end
        check("t1_cnt", 32'(cnt_o), 3);
        check("t1_q", 32'(q_o), 32'h2A5);
        check("t1_state", 32'(state_o), 1);

        // Auto mode from IDLE.
        cyc(1, 0, 0, 0);
        n_ticks = 0;
        first   = -1;
        for (int e = 0; e <= 12; e++) begin
            cyc(0, 0, 0, 1);
            if (tick_o) begin
                n_ticks++;
                if (first < 0) first = e;
            end
        end
        cyc(0, 0, 0, 1);
        check("t2_ticks", 32'(n_ticks), 3);
        check("t2_first", 32'(first), 4);
        check("t2_cnt", 32'(cnt_o), 3);

        // Up-wrap then down-wrap in MANUAL.
        cyc(0, 0, 0, 0);
        for (int i = 0; i < 6; i++) cyc(0, 1, 0, 0);
        check("t3_at_max", 32'(cnt_o), 9);
        cyc(0, 1, 0, 0);
        check("t3_upwrap_cnt", 32'(cnt_o), 0);
        check("t3_upwrap_flag", 32'(wrap_o), 1);
        cyc(0, 0, 0, 0);
        check("t3_wrap_pulse", 32'(wrap_o), 0);
        dir_i = 1;
        cyc(0, 1, 0, 0);
        check("t3_dnwrap_cnt", 32'(cnt_o), 9);
        check("t3_dnwrap_flag", 32'(wrap_o), 1);

        // Pause on a tick cycle, then resume.
        dir_i = 0;
        cyc(0, 0, 0, 1);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1);
        check("t4_tick_now", 32'(tick_o), 1);
        held = cnt_o;
        cyc(0, 1, 0, 1);
        check("t4_paused", 32'(state_o), 3);
        check("t4_cnt_held", 32'(cnt_o), 32'(held));
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        cyc(0, 1, 0, 1);
        check("t4_resumed", 32'(state_o), 2);
        first = -1;
        for (int e = 1; e <= 8 && first < 0; e++) begin
            cyc(0, 0, 0, 1);
            if (tick_o) first = e;
        end
        check("t4_next_tick", 32'(first), 4);

        // Clear wins over a coincident click.
        cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 0);
        sw_i = 10'h155;
        for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0);
        check("t5_pre_cnt", 32'(cnt_o), 5);
        sw_i = 10'h3FF;
        cyc(0, 1, 1, 0);
        check("t5_cnt", 32'(cnt_o), 0);
        check("t5_q", 32'(q_o), 32'h155);
        check("t5_wrap", 32'(wrap_o), 0);

        // Reset in the middle of AUTO.
        for (int i = 0; i < 7; i++) cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        check("t6_pre_cnt", 32'(cnt_o), 7);
        cyc(1, 0, 0, 1);
        check("t6_cnt", 32'(cnt_o), 0);
        check("t6_q", 32'(q_o), 0);
        check("t6_state", 32'(state_o), 0);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 0);
            check("t6_no_tick", 32'(tick_o), 0);
        end

        // Random traffic; run_i is a slow switch.
        for (int i = 0; i < 1500; i++) begin
            logic r, c, cl, rn;
            r  = ($urandom_range(0, 99) == 0);
            c  = ($urandom_range(0, 3) == 0);
            cl = ($urandom_range(0, 15) == 0);
            rn = ($urandom_range(0, 9) == 0) ? ~run_i : run_i;
            dir_i = ($urandom_range(0, 4) == 0) ? ~dir_i : dir_i;
            sw_i  = 10'($urandom);
            cyc(r, c, cl, rn);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
